bram_stream_reader: RTL and testbench

Upstream feeder for the AXIS master adapter. On a START pulse it reads LEN consecutive words from a 1-cycle-latency BRAM port, beginning at BASE_ADDR. It presents the words on the adapter's DIN_* handshake (DOUT_DATA/VALID/TLAST in, DOUT_ACCEP back) and flags the final word with TLAST. A 2-entry internal FIFO absorbs BRAM read latency, so the block sustains one word per cycle with no data loss under arbitrary DOUT_ACCEP stalls.

---
 rtl/bram_stream_reader.sv | 136 +++++++++++++
 tb/tb_bram_stream_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Reads LEN consecutive words from a 1-cycle-latency BRAM starting at BASE_ADDR
// and streams them out through a 2-entry FIFO with valid/accept handshake.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  BRAM_EN,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [DATA_WIDTH-1:0] BRAM_DOUT,
  output logic [DATA_WIDTH-1:0] DOUT_DATA,
  output logic                  DOUT_VALID,
  output logic                  DOUT_TLAST,
  input  logic                  DOUT_ACCEP
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   received;
  logic [ADDR_WIDTH:0]   accepted;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] data_mem [2];
  logic                  last_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;

  // Words already stored or still coming back from the BRAM, after this cycle's pop.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign pop       = DOUT_VALID && DOUT_ACCEP;
  assign push      = inflight;
  assign issue     = (state == RUN) && (issued < len) && (occupancy < 3'd2);

  assign BRAM_EN    = issue;
  assign BRAM_ADDR  = base + issued[ADDR_WIDTH-1:0];
  assign DOUT_VALID = (fifo_count != 2'd0);
  assign DOUT_DATA  = data_mem[rd_ptr];
  assign DOUT_TLAST = DOUT_VALID && last_mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      base     <= '0;
      len      <= '0;
      issued   <= '0;
      received <= '0;
      accepted <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (LEN != '0) begin
              base     <= BASE_ADDR;
              len      <= LEN;
              issued   <= '0;
              received <= '0;
              accepted <= '0;
              BUSY     <= 1'b1;
              state    <= RUN;
            end else begin
              DONE  <= 1'b1;
              state <= ZERO;
            end
          end
        end
        RUN: begin
          if (issue) issued <= issued + 1'b1;
          if (push) received <= received + 1'b1;
          if (pop) begin
            accepted <= accepted + 1'b1;
            if (accepted == len - 1'b1) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= FIN;
            end
          end
        end
        ZERO:    state <= IDLE;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The last flag travels with each word so TLAST needs no compare on the output side.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      last_mem[0] <= 1'b0;
      last_mem[1] <= 1'b0;
    end else begin
      inflight <= issue;
      if (push) begin
        data_mem[wr_ptr] <= BRAM_DOUT;
        last_mem[wr_ptr] <= (received == len - 1'b1);
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: table of transfers plus random runs, each checked cycle by
// cycle against a queue-free counting model of the word stream.
module tb_bram_stream_reader;

  logic        ACLK;
  logic        ARESET;
  logic        START;
  logic [9:0]  BASE_ADDR;
  logic [10:0] LEN;
  logic        BUSY;
  logic        DONE;
  logic        BRAM_EN;
  logic [9:0]  BRAM_ADDR;
  logic [31:0] BRAM_DOUT;
  logic [31:0] DOUT_DATA;
  logic        DOUT_VALID;
  logic        DOUT_TLAST;
  logic        DOUT_ACCEP;

  logic [31:0] mem [1024];
  int          checks;
  int          errors;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    int          mode;
    int          exp_done;
    bit          restart;
  } vec_t;

  vec_t vecs [9];

  bram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .START      (START),
    .BASE_ADDR  (BASE_ADDR),
    .LEN        (LEN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .BRAM_EN    (BRAM_EN),
    .BRAM_ADDR  (BRAM_ADDR),
    .BRAM_DOUT  (BRAM_DOUT),
    .DOUT_DATA  (DOUT_DATA),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_TLAST (DOUT_TLAST),
    .DOUT_ACCEP (DOUT_ACCEP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Behavioural BRAM: one cycle read latency.
  always @(posedge ACLK) begin
    if (BRAM_EN) BRAM_DOUT <= mem[BRAM_ADDR];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic accep_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c >= 6 && c <= 10) ? 1'b0 : ((c % 4 == 0) || (c % 4 == 3));
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One transfer from START (cycle 0) until DONE, plus one idle cycle afterwards.
  task automatic applyStimulus(input logic [9:0] base, input logic [10:0] len, input int mode,
                               input int exp_done, input bit restart);
    int issues;
    int pops;
    int en_prev;
    int model_done;
    int done_cycle;
    int budget;
    int ilen;
    logic prev_stall;
    logic [31:0] prev_data;
    logic prev_tlast;
    issues = 0;
    pops = 0;
    en_prev = 0;
    ilen = int'(len);
    model_done = (ilen == 0) ? 1 : 32'h4000_0000;
    done_cycle = -1;
    budget = ilen * 20 + 50;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_tlast = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge ACLK);
      START      = (c == 0) || (restart && c == 5);
      BASE_ADDR  = (c == 0) ? base : 10'($urandom);
      LEN        = (c == 0) ? len : 11'($urandom_range(1, 2047));
      DOUT_ACCEP = accep_for(mode, c);
      #1;
      checkOutput("busy", longint'(BUSY), longint'(c >= 1 && c < model_done));
      checkOutput("done", longint'(DONE), longint'(c == model_done));
      checkOutput("valid", longint'(DOUT_VALID), longint'((issues - pops - en_prev) > 0));
      checkOutput("occupancy_le2", longint'((issues - pops) <= 2), 1);
      if (prev_stall) begin
        checkOutput("stall_valid", longint'(DOUT_VALID), 1);
        checkOutput("stall_data", longint'(DOUT_DATA), longint'(prev_data));
        checkOutput("stall_tlast", longint'(DOUT_TLAST), longint'(prev_tlast));
      end
      if (c == 1 && ilen != 0) checkOutput("first_en", longint'(BRAM_EN), 1);
      if (BRAM_EN) begin
        checkOutput("addr", longint'(BRAM_ADDR), longint'((int'(base) + issues) % 1024));
        checkOutput("issue_limit", longint'(issues < ilen), 1);
        issues++;
      end
      if (DOUT_VALID && DOUT_ACCEP) begin
        checkOutput("data", longint'(DOUT_DATA), longint'(mem[(int'(base) + pops) % 1024]));
        checkOutput("tlast", longint'(DOUT_TLAST), longint'(pops == ilen - 1));
        pops++;
        if (pops == ilen) model_done = c + 1;
      end
      prev_stall = DOUT_VALID && !DOUT_ACCEP;
      prev_data  = DOUT_DATA;
      prev_tlast = DOUT_TLAST;
      en_prev    = int'(BRAM_EN);
      if (DONE) begin
        done_cycle = c;
        break;
      end
      if (c > model_done) break;
    end
    checkOutput("done_seen", longint'(done_cycle >= 0), 1);
    checkOutput("issued_total", longint'(issues), longint'(ilen));
    checkOutput("popped_total", longint'(pops), longint'(ilen));
    if (exp_done >= 0) checkOutput("done_cycle", longint'(done_cycle), longint'(exp_done));
    @(negedge ACLK);
    START      = 1'b0;
    DOUT_ACCEP = 1'($urandom);
    #1;
    checkOutput("done_once", longint'(DONE), 0);
    checkOutput("idle_busy", longint'(BUSY), 0);
    checkOutput("idle_en", longint'(BRAM_EN), 0);
    checkOutput("idle_valid", longint'(DOUT_VALID), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ARESET = 1'b1;
    START = 1'b0;
    BASE_ADDR = '0;
    LEN = '0;
    DOUT_ACCEP = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000 + i;

    vecs[0] = '{base: 10'h010, len: 11'd4,    mode: 0, exp_done: 7,    restart: 1'b0};
    vecs[1] = '{base: 10'h020, len: 11'd8,    mode: 1, exp_done: -1,   restart: 1'b0};
    vecs[2] = '{base: 10'h055, len: 11'd0,    mode: 0, exp_done: 1,    restart: 1'b0};
    vecs[3] = '{base: 10'h3FE, len: 11'd4,    mode: 0, exp_done: 7,    restart: 1'b0};
    vecs[4] = '{base: 10'h123, len: 11'd1,    mode: 0, exp_done: 4,    restart: 1'b0};
    vecs[5] = '{base: 10'h200, len: 11'd2,    mode: 0, exp_done: 5,    restart: 1'b0};
    vecs[6] = '{base: 10'h040, len: 11'd12,   mode: 0, exp_done: 15,   restart: 1'b1};
    vecs[7] = '{base: 10'h300, len: 11'd20,   mode: 2, exp_done: -1,   restart: 1'b0};
    vecs[8] = '{base: 10'h3F0, len: 11'd1024, mode: 0, exp_done: 1027, restart: 1'b0};

    repeat (2) @(negedge ACLK);
    #1;
    checkOutput("rst_busy", longint'(BUSY), 0);
    checkOutput("rst_done", longint'(DONE), 0);
    checkOutput("rst_en", longint'(BRAM_EN), 0);
    checkOutput("rst_addr", longint'(BRAM_ADDR), 0);
    checkOutput("rst_valid", longint'(DOUT_VALID), 0);
    checkOutput("rst_tlast", longint'(DOUT_TLAST), 0);
    checkOutput("rst_data", longint'(DOUT_DATA), 0);
    @(negedge ACLK);
    ARESET = 1'b0;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_done, vecs[v].restart);
    end

    // Reset one cycle after the second word transfers in a LEN=6 run.
    @(negedge ACLK);
    START = 1'b1; BASE_ADDR = 10'h100; LEN = 11'd6; DOUT_ACCEP = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    checkOutput("mid_word0", longint'(DOUT_DATA), longint'(mem[10'h100]));
    @(negedge ACLK);
    #1;
    checkOutput("mid_word1", longint'(DOUT_DATA), longint'(mem[10'h101]));
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    checkOutput("abort_busy", longint'(BUSY), 0);
    checkOutput("abort_done", longint'(DONE), 0);
    checkOutput("abort_en", longint'(BRAM_EN), 0);
    checkOutput("abort_addr", longint'(BRAM_ADDR), 0);
    checkOutput("abort_valid", longint'(DOUT_VALID), 0);
    checkOutput("abort_tlast", longint'(DOUT_TLAST), 0);
    checkOutput("abort_data", longint'(DOUT_DATA), 0);
    repeat (3) begin
      @(negedge ACLK);
      #1;
      checkOutput("abort_no_done", longint'(DONE), 0);
      checkOutput("abort_idle_valid", longint'(DOUT_VALID), 0);
    end
    applyStimulus(10'h000, 11'd2, 0, 5, 1'b0);

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int r = 0; r < 10; r++) begin
      applyStimulus(10'($urandom), 11'($urandom_range(0, 40)), 2, -1, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
